// File: rtl/cdc_fifo_pkg.sv
// Shared types and helpers for the CDC FIFO push-side arbiter.
package cdc_fifo_pkg;

    typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_t;

    // Wrapping increment of a round-robin pointer modulo n.
    function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
        return (ptr + 32'd1 >= n) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first requesting index at or after ptr, wrapping.
module rr_priority_pick #(
    parameter int unsigned NumReq = 4
) (
    input  logic [NumReq-1:0]         req,
    input  logic [$clog2(NumReq)-1:0] ptr,
    output logic                      found,
    output logic [$clog2(NumReq)-1:0] idx
);

    localparam int unsigned IdxW = $clog2(NumReq);

    logic [IdxW-1:0] cand;

    // Scan offsets from farthest to nearest so the nearest hit is the one that sticks.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int off = NumReq - 1; off >= 0; off--) begin
            cand = IdxW'((32'(ptr) + 32'(off)) % NumReq);
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/cdc_push_arbiter.sv
// Round-robin, burst-holding arbiter sharing one CDC FIFO push port among NumReq requesters.
// Optional source tag on the FIFO word: define CDC_ARB_SOURCE_TAG_EN.
module cdc_push_arbiter
    import cdc_fifo_pkg::*;
#(
    parameter int unsigned NumReq    = 4,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned MaxBurst  = 8
) (
    input  logic                          clk_DA,
    input  logic                          rst,
    input  logic [NumReq-1:0]             Req_DA,
    input  logic [NumReq-1:0]             ReqLast_DA,
    input  logic [NumReq*DataWidth-1:0]   ReqData_DA,
    output logic [NumReq-1:0]             Grant_DA,
    input  logic                          FifoFull_DA,
    output logic                          FifoPush_DA,
`ifdef CDC_ARB_SOURCE_TAG_EN
    output logic [DataWidth+$clog2(NumReq)-1:0] FifoData_DA,
`else
    output logic [DataWidth-1:0]          FifoData_DA,
`endif
    output logic                          Busy_DA,
    output logic [$clog2(NumReq)-1:0]     Owner_DA
);

    localparam int unsigned IdxW = $clog2(NumReq);
    localparam int unsigned CntW = $clog2(MaxBurst + 1);

    arb_state_t      state_q, state_d;
    logic [IdxW-1:0] owner_q, owner_d;
    logic [IdxW-1:0] ptr_q, ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic            pick_found;
    logic [IdxW-1:0] pick_idx;
    logic [DataWidth-1:0] owner_word;
    logic [CntW-1:0] cnt_inc;
    logic            beat;

    rr_priority_pick #(.NumReq(NumReq)) u_pick (
        .req   (Req_DA),
        .ptr   (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk_DA) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state plus the zero-latency grant/push/data path of the current owner.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        Grant_DA    = '0;
        FifoPush_DA = 1'b0;
        FifoData_DA = '0;
        Busy_DA     = 1'b0;
        Owner_DA    = owner_q;
        beat        = 1'b0;
        cnt_inc     = cnt_q + CntW'(1);
        owner_word  = ReqData_DA[32'(owner_q) * DataWidth +: DataWidth];

        case (state_q)
            ARB_IDLE: begin
                if (pick_found) begin
                    owner_d = pick_idx;
                    cnt_d   = '0;
                    state_d = ARB_BURST;
                end
            end
            ARB_BURST: begin
                Busy_DA = 1'b1;
                if (!FifoFull_DA) begin
                    Grant_DA[owner_q] = 1'b1;
                end
                beat        = Req_DA[owner_q] & ~FifoFull_DA;
                FifoPush_DA = beat;
`ifdef CDC_ARB_SOURCE_TAG_EN
                FifoData_DA = {owner_q, owner_word};
`else
                FifoData_DA = owner_word;
`endif
                // Release on end of packet or when the burst budget is used up.
                if (beat) begin
                    cnt_d = cnt_inc;
                    if (ReqLast_DA[owner_q] || (cnt_inc == CntW'(MaxBurst))) begin
                        state_d = ARB_IDLE;
                        ptr_d   = IdxW'(rr_next(32'(owner_q), NumReq));
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

endmodule

// File: tb/tb_cdc_push_arbiter.sv
// Directed self-checking bench for cdc_push_arbiter (NumReq=4, DataWidth=32, MaxBurst=8).
module tb_cdc_push_arbiter;

`ifdef CDC_ARB_SOURCE_TAG_EN
    localparam int OW = 34;
`else
    localparam int OW = 32;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    req, last, grant;
    logic [127:0]  data;
    logic          full, push, busy;
    logic [OW-1:0] fdata;
    logic [1:0]    owner;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cdc_push_arbiter #(.NumReq(4), .DataWidth(32), .MaxBurst(8)) dut (
        .clk_DA      (clk),
        .rst         (rst),
        .Req_DA      (req),
        .ReqLast_DA  (last),
        .ReqData_DA  (data),
        .Grant_DA    (grant),
        .FifoFull_DA (full),
        .FifoPush_DA (push),
        .FifoData_DA (fdata),
        .Busy_DA     (busy),
        .Owner_DA    (owner)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic b, input logic [1:0] o,
                           input logic [3:0] g, input logic p, input logic [63:0] d);
        chk({tag, ".busy"},  64'(busy),  64'(b));
        chk({tag, ".owner"}, 64'(owner), 64'(o));
        chk({tag, ".grant"}, 64'(grant), 64'(g));
        chk({tag, ".push"},  64'(push),  64'(p));
        chk({tag, ".data"},  64'(fdata), d);
    endtask

    function automatic logic [63:0] fexp(input logic [1:0] idx, input logic [31:0] w);
`ifdef CDC_ARB_SOURCE_TAG_EN
        return 64'({idx, w});
`else
        return 64'(w);
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1; req = '0; last = '0; data = '0; full = 1'b0;

        // Reset then idle
        tick(); tick();
        settle(); chk_out("reset", 1'b0, 2'd0, 4'b0000, 1'b0, 64'd0);
        rst = 1'b0;
        tick(); settle(); chk_out("idle", 1'b0, 2'd0, 4'b0000, 1'b0, 64'd0);

        // Round-robin order 0,1,2,3,0 with single-beat packets
        for (int i = 0; i < 4; i++) data[i*32 +: 32] = 32'hC0DE0000 + 32'(i);
        req = 4'hF; last = 4'hF;
        for (int k = 0; k < 5; k++) begin
            tick(); settle();
            chk_out($sformatf("rr_grant%0d", k), 1'b1, 2'(k % 4), 4'(1 << (k % 4)), 1'b1,
                    fexp(2'(k % 4), 32'hC0DE0000 + 32'(k % 4)));
            tick();
            if (k == 4) begin req = '0; last = '0; end
            settle();
            chk_out($sformatf("rr_gap%0d", k), 1'b0, 2'(k % 4), 4'b0000, 1'b0, 64'd0);
        end

        // Packet hold: owner 1 drops Req for two cycles while requester 2 waits
        req = 4'b0110; last = 4'b0000; data[32 +: 32] = 32'h11110001;
        tick(); settle(); chk_out("hold_b1", 1'b1, 2'd1, 4'b0010, 1'b1, fexp(2'd1, 32'h11110001));
        tick(); req = 4'b0100; settle();
        chk_out("hold_drop0", 1'b1, 2'd1, 4'b0010, 1'b0, fexp(2'd1, 32'h11110001));
        tick(); settle();
        chk_out("hold_drop1", 1'b1, 2'd1, 4'b0010, 1'b0, fexp(2'd1, 32'h11110001));
        tick(); req = 4'b0110; data[32 +: 32] = 32'h11110002; settle();
        chk_out("hold_b2", 1'b1, 2'd1, 4'b0010, 1'b1, fexp(2'd1, 32'h11110002));
        tick(); data[32 +: 32] = 32'h11110003; last = 4'b0010; settle();
        chk_out("hold_b3", 1'b1, 2'd1, 4'b0010, 1'b1, fexp(2'd1, 32'h11110003));
        tick(); last = 4'b0000; settle();
        chk_out("hold_rel", 1'b0, 2'd1, 4'b0000, 1'b0, 64'd0);
        tick(); last = 4'b0100; settle();
        chk_out("hold_next", 1'b1, 2'd2, 4'b0100, 1'b1, fexp(2'd2, 32'hC0DE0002));
        tick(); req = '0; last = '0; settle();
        chk_out("hold_done", 1'b0, 2'd2, 4'b0000, 1'b0, 64'd0);

        // Pointer at 3: one beat from 3 wraps pointer to 0, then forced release of 0
        req = 4'b1001; last = 4'b1000; data[96 +: 32] = 32'h33330000;
        tick(); settle(); chk_out("wrap3", 1'b1, 2'd3, 4'b1000, 1'b1, fexp(2'd3, 32'h33330000));
        tick(); last = 4'b0000; settle();
        chk_out("wrap3_rel", 1'b0, 2'd3, 4'b0000, 1'b0, 64'd0);
        for (int b = 0; b < 8; b++) begin
            tick(); data[0 +: 32] = 32'hD0000000 + 32'(b); settle();
            chk_out($sformatf("force_b%0d", b), 1'b1, 2'd0, 4'b0001, 1'b1,
                    fexp(2'd0, 32'hD0000000 + 32'(b)));
        end
        tick(); last = 4'b1000; settle();
        chk_out("force_rel", 1'b0, 2'd0, 4'b0000, 1'b0, 64'd0);
        tick(); req = 4'b1000; settle();
        chk_out("force_next", 1'b1, 2'd3, 4'b1000, 1'b1, fexp(2'd3, 32'h33330000));
        tick(); req = '0; last = '0; settle();
        chk_out("force_done", 1'b0, 2'd3, 4'b0000, 1'b0, 64'd0);

        // Backpressure: 5 full cycles mid-burst; counter must freeze
        req = 4'b0001; data[0 +: 32] = 32'hE0000000;
        tick(); settle(); chk_out("bp_b0", 1'b1, 2'd0, 4'b0001, 1'b1, fexp(2'd0, 32'hE0000000));
        tick(); data[0 +: 32] = 32'hE0000001; full = 1'b1; settle();
        chk_out("bp_full0", 1'b1, 2'd0, 4'b0000, 1'b0, fexp(2'd0, 32'hE0000001));
        for (int f = 1; f < 5; f++) begin
            tick(); settle();
            chk_out($sformatf("bp_full%0d", f), 1'b1, 2'd0, 4'b0000, 1'b0, fexp(2'd0, 32'hE0000001));
        end
        tick(); full = 1'b0; settle();
        chk_out("bp_resume", 1'b1, 2'd0, 4'b0001, 1'b1, fexp(2'd0, 32'hE0000001));
        for (int b = 2; b < 8; b++) begin
            tick(); data[0 +: 32] = 32'hE0000000 + 32'(b); settle();
            chk_out($sformatf("bp_b%0d", b), 1'b1, 2'd0, 4'b0001, 1'b1,
                    fexp(2'd0, 32'hE0000000 + 32'(b)));
        end
        tick(); req = '0; settle();
        chk_out("bp_rel", 1'b0, 2'd0, 4'b0000, 1'b0, 64'd0);

        // Data/tag path, then reset mid-burst
        req = 4'b0100; data[64 +: 32] = 32'hA5A5A5A5;
        tick(); settle(); chk_out("tag", 1'b1, 2'd2, 4'b0100, 1'b1, fexp(2'd2, 32'hA5A5A5A5));
        rst = 1'b1;
        tick(); rst = 1'b0; req = 4'b1001; settle();
        chk_out("rst_mid", 1'b0, 2'd0, 4'b0000, 1'b0, 64'd0);
        tick(); settle();
        chk_out("rst_ptr", 1'b1, 2'd0, 4'b0001, 1'b1, fexp(2'd0, 32'hE0000007));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
